// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch slice.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // True when a fetch PC is not word aligned.
  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

  // True when a fetch PC lies inside the instruction memory.
  function automatic logic pc_in_range(input logic [XLEN-1:0] pc,
                                       input logic [XLEN-1:0] limit);
    return (pc < limit);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs with flush.
module fetch_queue
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head_entry,
  output logic         full,
  output logic         empty
);

  fetch_entry_t slot_r [2];
  logic         rd_ptr_r;
  logic         wr_ptr_r;
  logic [1:0]   count_r;

  // Pointer and occupancy bookkeeping; flush discards everything.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      slot_r[wr_ptr_r] <= push_entry;
    end
  end

  assign head_entry = slot_r[rd_ptr_r];
  assign full       = (count_r == 2'd2);
  assign empty      = (count_r == 2'd0);

  fetch_queue_checker u_checker (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .count (count_r)
  );

endmodule

// File: rtl/fetch_queue_checker.sv
// Structural invariants of the two-entry fetch queue.
module fetch_queue_checker (
  input logic       clk,
  input logic       rst,
  input logic       push,
  input logic       pop,
  input logic       flush,
  input logic [1:0] count
);

  // Occupancy can never exceed the two physical slots.
  a_count_max: assert property (@(posedge clk) disable iff (rst) count <= 2'd2);

  // A pop is only legal when something is queued.
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    (pop && !flush) |-> (count != 2'd0));

  // A push into a full queue must be paired with a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && !flush && count == 2'd2) |-> pop);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC ownership, fetch queue control, redirects and sticky fault.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              MEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_instr,
  output logic            if_valid,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_pc
);

  // First byte address past the end of instruction memory.
  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(MEM_DEPTH * 4);

  fetch_state_t    state_r, state_next_s;
  logic [XLEN-1:0] pc_r, pc_next_s;
  logic            fault_r, fault_next_s;
  logic [XLEN-1:0] fault_pc_r, fault_pc_next_s;

  logic            push_s;
  logic            flush_s;
  logic            pop_s;
  logic            q_full_s;
  logic            q_empty_s;
  logic            pc_ok_s;
  logic            redirect_bad_s;
  fetch_entry_t    push_entry_s;
  fetch_entry_t    head_entry_s;

  assign pc_ok_s        = !pc_misaligned(pc_r) && pc_in_range(pc_r, PC_LIMIT);
  assign redirect_bad_s = pc_misaligned(redirect_pc) || !pc_in_range(redirect_pc, PC_LIMIT);

  // Nothing is presented to decode once faulted.
  assign if_valid = (state_r == FETCH) && !q_empty_s;
  assign pop_s    = if_valid && id_ready;

  assign push_entry_s = '{pc: pc_r, instr: imem_instr};

  // State, PC and fault capture registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FETCH;
      pc_r       <= RESET_PC;
      fault_r    <= 1'b0;
      fault_pc_r <= 32'h0000_0000;
    end else begin
      state_r    <= state_next_s;
      pc_r       <= pc_next_s;
      fault_r    <= fault_next_s;
      fault_pc_r <= fault_pc_next_s;
    end
  end

  // Next-state, PC update and queue push/flush decisions.
  always_comb begin
    state_next_s    = state_r;
    pc_next_s       = pc_r;
    fault_next_s    = fault_r;
    fault_pc_next_s = fault_pc_r;
    push_s          = 1'b0;
    flush_s         = 1'b0;
    case (state_r)
      FETCH: begin
        if (redirect_valid) begin
          // Redirect kills everything queued; a same-cycle pop is harmless.
          flush_s = 1'b1;
          if (redirect_bad_s) begin
            state_next_s    = FAULT;
            fault_next_s    = 1'b1;
            fault_pc_next_s = redirect_pc;
          end else begin
            pc_next_s = redirect_pc;
          end
        end else if (!pc_ok_s) begin
          // Sequential fetch ran off the end of memory.
          flush_s         = 1'b1;
          state_next_s    = FAULT;
          fault_next_s    = 1'b1;
          fault_pc_next_s = pc_r;
        end else if (!q_full_s || pop_s) begin
          push_s    = 1'b1;
          pc_next_s = pc_r + 32'd4;
        end else begin
          push_s = 1'b0;
        end
      end
      FAULT: begin
        state_next_s = FAULT;
      end
      default: begin
        state_next_s = FAULT;
        fault_next_s = 1'b1;
        flush_s      = 1'b1;
      end
    endcase
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .pop        (pop_s),
    .flush      (flush_s),
    .push_entry (push_entry_s),
    .head_entry (head_entry_s),
    .full       (q_full_s),
    .empty      (q_empty_s)
  );

  assign imem_addr   = pc_r;
  assign if_instr    = head_entry_s.instr;
  assign if_pc       = head_entry_s.pc;
  assign fetch_fault = fault_r;
  assign fault_pc    = fault_pc_r;

endmodule
